// File: rtl/instr_encoder_if.sv
// Command channel into the instruction encoder: symbolic instruction fields
// plus a valid/ready handshake. The producer drives the master side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS commands into 32-bit instruction words and writes them
// to consecutive instruction-memory addresses from 0; acts as the program preloader.
module instr_encoder #(
  parameter int AW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_encoder_if.slave    cmd,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [31:0]       imem_wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AW:0]       count
);

  localparam logic [3:0] K_ADD  = 4'd0;
  localparam logic [3:0] K_SUB  = 4'd1;
  localparam logic [3:0] K_AND  = 4'd2;
  localparam logic [3:0] K_OR   = 4'd3;
  localparam logic [3:0] K_SLT  = 4'd4;
  localparam logic [3:0] K_LW   = 4'd5;
  localparam logic [3:0] K_SW   = 4'd6;
  localparam logic [3:0] K_BEQ  = 4'd7;
  localparam logic [3:0] K_BNE  = 4'd8;
  localparam logic [3:0] K_ADDI = 4'd9;
  localparam logic [3:0] K_J    = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   last_p1;
  logic   accept;
  logic   kind_ok;
  logic   restart;

  function automatic logic is_legal(input logic [3:0] kind);
    return (kind <= K_J);
  endfunction

  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      K_ADD:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FN_ADD};
      K_SUB:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SUB};
      K_AND:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FN_AND};
      K_OR:    w = {OP_RTYPE, rs, rt, rd, 5'b0, FN_OR};
      K_SLT:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SLT};
      K_LW:    w = {OP_LW,   rs, rt, imm};
      K_SW:    w = {OP_SW,   rs, rt, imm};
      K_BEQ:   w = {OP_BEQ,  rs, rt, imm};
      K_BNE:   w = {OP_BNE,  rs, rt, imm};
      K_ADDI:  w = {OP_ADDI, rs, rt, imm};
      K_J:     w = {OP_J, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign kind_ok = is_legal(cmd.in_kind);
  assign accept  = (state == S_LOAD) && cmd.in_valid;
  assign restart = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cmd.in_ready = 1'b0;
    imem_we      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cmd.in_ready = 1'b1;
        busy         = 1'b1;
        if (cmd.in_valid) state_nxt = kind_ok ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        // Overflow ends the session once the top address has been written.
        if (last_p1 || (&imem_addr)) state_nxt = S_DONE;
        else                         state_nxt = S_LOAD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: encoded word and last flag captured on acceptance, address/count advance after the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_addr <= '0;
      imem_wd   <= '0;
      count     <= '0;
      err       <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      if (restart) begin
        imem_addr <= '0;
        count     <= '0;
        err       <= 1'b0;
      end
      if (accept) begin
        if (kind_ok) begin
          imem_wd <= encode(cmd.in_kind, cmd.in_rs, cmd.in_rt, cmd.in_rd,
                            cmd.in_imm, cmd.in_target);
          last_p1 <= cmd.in_last;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == S_WRITE) begin
        imem_addr <= imem_addr + 1'b1;
        count     <= count + 1'b1;
        if (!last_p1 && (&imem_addr)) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 64-word instance for encoding/session
// behaviour and a 4-word instance for the memory-overflow case.
module tb_instr_encoder;

  logic clk;
  logic reset;
  logic start_a, start_b;

  logic        we_a, busy_a, done_a, err_a;
  logic [5:0]  addr_a;
  logic [31:0] wd_a;
  logic [6:0]  count_a;

  logic        we_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [2:0]  count_b;

  int checks = 0;
  int errors = 0;

  instr_encoder_if ia ();
  instr_encoder_if ib ();

  instr_encoder #(.AW(6)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cmd(ia),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wd(wd_a),
    .busy(busy_a), .done(done_a), .err(err_a), .count(count_a)
  );

  instr_encoder #(.AW(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cmd(ib),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wd(wd_b),
    .busy(busy_b), .done(done_b), .err(err_b), .count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge inside the write cycle.
  task automatic send_a(input string tag, input logic [3:0] kind,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                        input logic exp_wr, input logic [5:0] exp_addr,
                        input logic [31:0] exp_word);
    ia.in_valid = 1'b1; ia.in_kind = kind; ia.in_rs = rs; ia.in_rt = rt;
    ia.in_rd = rd; ia.in_imm = imm; ia.in_target = tgt; ia.in_last = last;
    for (int n = 0; n < 20 && !ia.in_ready; n++) @(negedge clk);
    if (!ia.in_ready) begin
      chk({tag, "_accept_timeout"}, ia.in_ready, 1);
      ia.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ia.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_we"}, we_a, exp_wr);
    chk({tag, "_ready_low"}, ia.in_ready, 0);
    if (exp_wr) begin
      chk({tag, "_addr"}, addr_a, exp_addr);
      chk({tag, "_wd"}, wd_a, exp_word);
    end
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ia.in_valid = 1'b0; ia.in_kind = '0; ia.in_rs = '0; ia.in_rt = '0; ia.in_rd = '0;
    ia.in_imm = '0; ia.in_target = '0; ia.in_last = 1'b0;
    ib.in_valid = 1'b0; ib.in_kind = '0; ib.in_rs = '0; ib.in_rt = '0; ib.in_rd = '0;
    ib.in_imm = '0; ib.in_target = '0; ib.in_last = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    chk("rst_ready", ia.in_ready, 0);
    chk("rst_we", we_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wd", wd_a, 0);

    // valid held in IDLE: nothing accepted
    ia.in_valid = 1'b1; ia.in_kind = 4'd0;
    repeat (3) @(negedge clk);
    chk("idle_ready", ia.in_ready, 0);
    chk("idle_busy", busy_a, 0);
    ia.in_valid = 1'b0;

    // reset asserted in the middle of a write cycle
    pulse_start_a();
    chk("start_ready", ia.in_ready, 1);
    chk("start_busy", busy_a, 1);
    ia.in_valid = 1'b1; ia.in_kind = 4'd0; ia.in_rs = 5'd1; ia.in_rt = 5'd2; ia.in_rd = 5'd3;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_we", we_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_addr", addr_a, 0);
    chk("midrst_wd", wd_a, 0);
    chk("midrst_count", count_a, 0);
    ia.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_we_hold", we_a, 0);
    reset = 1'b1;
    @(negedge clk);

    // ADD then LW
    pulse_start_a();
    send_a("add", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 6'd0, 32'h00221820);
    chk("add_count_before", count_a, 0);
    @(negedge clk);
    send_a("lw", 4'd5, 5'd0, 5'd2, 5'd9, 16'h0004, 26'h0, 1'b1, 1'b1, 6'd1, 32'h8C020004);
    chk("lw_done_early", done_a, 0);
    @(negedge clk);
    chk("p1_count", count_a, 2);
    chk("p1_done", done_a, 1);
    chk("p1_err", err_a, 0);
    chk("p1_busy", busy_a, 0);

    // valid held in DONE: nothing accepted
    ia.in_valid = 1'b1; ia.in_kind = 4'd1;
    repeat (3) @(negedge clk);
    chk("done_ready", ia.in_ready, 0);
    chk("done_we", we_a, 0);
    chk("done_count", count_a, 2);
    ia.in_valid = 1'b0;

    // Mixed I/J program, start pulsed mid-session
    pulse_start_a();
    chk("p2_count_clear", count_a, 0);
    chk("p2_done_clear", done_a, 0);
    send_a("sw", 4'd6, 5'd0, 5'd2, 5'd7, 16'h0008, 26'h3FFFFFF, 1'b0, 1'b1, 6'd0, 32'hAC020008);
    @(negedge clk);
    pulse_start_a();
    chk("ign_start_busy", busy_a, 1);
    send_a("beq", 4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 6'd1, 32'h1022FFFF);
    @(negedge clk);
    send_a("bne", 4'd8, 5'd1, 5'd2, 5'd0, 16'h0002, 26'h0, 1'b0, 1'b1, 6'd2, 32'h14220002);
    @(negedge clk);
    send_a("addi", 4'd9, 5'd0, 5'd2, 5'd0, 16'h0005, 26'h0, 1'b0, 1'b1, 6'd3, 32'h20020005);
    @(negedge clk);
    send_a("j", 4'd10, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 1'b1, 1'b1, 6'd4, 32'h08000010);
    @(negedge clk);
    chk("p2_count", count_a, 5);
    chk("p2_done", done_a, 1);
    chk("p2_err", err_a, 0);

    // Illegal kind as second command
    pulse_start_a();
    send_a("ill_first", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 6'd0, 32'h00221820);
    @(negedge clk);
    send_a("ill_kind", 4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("ill_done", done_a, 1);
    chk("ill_err", err_a, 1);
    chk("ill_count", count_a, 1);
    @(negedge clk);
    chk("ill_err_hold", err_a, 1);
    pulse_start_a();
    chk("ill_err_clear", err_a, 0);
    send_a("sub", 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 6'd0, 32'h00221822);
    @(negedge clk);
    send_a("and", 4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 6'd1, 32'h00221824);
    @(negedge clk);
    send_a("slt", 4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 6'd2, 32'h0022182A);
    @(negedge clk);
    send_a("or", 4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, 1'b1, 6'd3, 32'h00853025);
    @(negedge clk);
    chk("p3_count", count_a, 4);
    chk("p3_err", err_a, 0);

    // Overflow on the 4-word instance
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ib.in_valid = 1'b1; ib.in_kind = 4'd9; ib.in_rs = 5'd0; ib.in_rt = i[4:0];
      ib.in_imm = i[15:0]; ib.in_last = 1'b0;
      for (int n = 0; n < 6 && !ib.in_ready; n++) @(negedge clk);
      if (i < 4) begin
        chk("ovf_accept", ib.in_ready, 1);
        if (ib.in_ready) begin
          @(posedge clk);
          #1 ib.in_valid = 1'b0;
          @(negedge clk);
          chk("ovf_we", we_b, 1);
          chk("ovf_addr", addr_b, i[1:0]);
          chk("ovf_wd", wd_b, 32'h20000000 | (i << 16) | i);
        end
      end else begin
        chk("ovf_no_accept", ib.in_ready, 0);
        chk("ovf_no_we", we_b, 0);
        ib.in_valid = 1'b0;
      end
    end
    chk("ovf_count", count_b, 4);
    chk("ovf_err", err_b, 1);
    chk("ovf_done", done_b, 1);
    chk("ovf_busy", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
